// File: rtl/hwpe_stream_fifo_earlystall_param.sv
// hwpe_stream_fifo_earlystall_param: any-depth stream FIFO with programmable early-stall margin, occupancy and sticky overflow.
module hwpe_stream_fifo_earlystall_param #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              push_valid_i,
  output logic                              push_ready_o,
  input  logic [DATA_WIDTH-1:0]             push_data_i,
  input  logic [DATA_WIDTH/8-1:0]           push_strb_i,
  output logic                              pop_valid_o,
  input  logic                              pop_ready_i,
  output logic [DATA_WIDTH-1:0]             pop_data_o,
  output logic [DATA_WIDTH/8-1:0]           pop_strb_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy_o,
  output logic                              overflow_o
);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = DATA_WIDTH + SW;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop;
  logic [EW-1:0] head;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full         = count_q == CW'(FIFO_DEPTH);
    push_ready_o = count_q < CW'(FIFO_DEPTH - STALL_MARGIN);
    pop_valid_o  = count_q != '0;
    head         = pop_valid_o ? mem_q[rd_ptr_q] : '0;
    pop_data_o   = head[EW-1:SW];
    pop_strb_o   = head[SW-1:0];
    occupancy_o  = count_q;
    overflow_o   = ovf_q;
    pop          = pop_valid_o & pop_ready_i;
    // Margin beats are accepted regardless of push_ready_o; only a truly full FIFO refuses.
    push         = push_valid_i & (~full | pop);
    wr_ptr_d     = clear_i ? '0 : push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = clear_i ? '0 : pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d      = clear_i ? '0 : (push & ~pop) ? count_q + CW'(1) :
                   (pop & ~push) ? count_q - CW'(1) : count_q;
    ovf_d        = ~clear_i & (ovf_q | (push_valid_i & full & ~pop));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push && !clear_i) mem_q[wr_ptr_q] <= {push_data_i, push_strb_i};
    end
  end
endmodule

// File: tb/tb_hwpe_stream_fifo_earlystall_param.sv
// tb_hwpe_stream_fifo_earlystall_param: directed checks on an 8/2 FIFO plus an ordered random stream through a 6/1 FIFO.
module tb_hwpe_stream_fifo_earlystall_param;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic        a_clear = 0, a_pv = 0, a_pr_o, a_vv_o, a_rdy = 0, a_ovf;
  logic [31:0] a_d = 0, a_qd;
  logic [3:0]  a_s = 0, a_qs, a_occ;
  logic        b_clear = 0, b_pv = 0, b_pr_o, b_vv_o, b_rdy = 0, b_ovf;
  logic [31:0] b_d = 0, b_qd;
  logic [3:0]  b_s = 4'hf, b_qs;
  logic [2:0]  b_occ;

  int n_tests = 0, n_fail = 0;

  hwpe_stream_fifo_earlystall_param #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .STALL_MARGIN(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(a_clear), .push_valid_i(a_pv), .push_ready_o(a_pr_o),
    .push_data_i(a_d), .push_strb_i(a_s), .pop_valid_o(a_vv_o), .pop_ready_i(a_rdy),
    .pop_data_o(a_qd), .pop_strb_o(a_qs), .occupancy_o(a_occ), .overflow_o(a_ovf));

  hwpe_stream_fifo_earlystall_param #(.DATA_WIDTH(32), .FIFO_DEPTH(6), .STALL_MARGIN(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(b_clear), .push_valid_i(b_pv), .push_ready_o(b_pr_o),
    .push_data_i(b_d), .push_strb_i(b_s), .pop_valid_o(b_vv_o), .pop_ready_i(b_rdy),
    .pop_data_o(b_qd), .pop_strb_o(b_qs), .occupancy_o(b_occ), .overflow_o(b_ovf));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] d, input logic [3:0] s, input logic pr);
    a_pv = 1; a_d = d; a_s = s; a_rdy = pr;
    tick();
    a_pv = 0; a_rdy = 0;
  endtask

  task automatic idle_a;
    chk("idle_ready", a_pr_o, 1);
    chk("idle_valid", a_vv_o, 0);
    chk("idle_data", a_qd, 0);
    chk("idle_strb", a_qs, 0);
    chk("idle_occ", a_occ, 0);
  endtask

  int sent, recv, max_occ, cyc;
  logic rdy_prev;

  initial begin
    #1;
    idle_a();
    chk("rst_ovf", a_ovf, 0);
    tick(); tick();
    rst = 0;
    tick();
    // Asynchronous reset pulse mid-cycle with data stored
    push_a(32'h11, 4'hf, 0);
    push_a(32'h22, 4'hf, 0);
    chk("pre_rst_occ", a_occ, 2);
    #2 rst = 1;
    #1;
    idle_a();
    chk("async_rst_ovf", a_ovf, 0);
    #1 rst = 0;
    tick();

    // Early stall: margin beats accepted after ready drops
    for (int i = 0; i < 6; i++) push_a(32'hA0 + i, 4'hf, 0);
    chk("es_occ6", a_occ, 6);
    chk("es_ready6", a_pr_o, 0);
    push_a(32'hA6, 4'hf, 0);
    push_a(32'hA7, 4'hf, 0);
    chk("es_occ8", a_occ, 8);
    chk("es_ovf8", a_ovf, 0);
    a_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk("es_valid", a_vv_o, 1);
      chk("es_data", a_qd, 32'hA0 + i);
      chk("es_occ", a_occ, 8 - i);
      chk("es_ready", a_pr_o, i >= 3);
      tick();
    end
    a_rdy = 0;
    idle_a();

    // Overflow handling at full
    for (int i = 0; i < 8; i++) push_a(32'hB0 + i, 4'hf, 0);
    push_a(32'hBB, 4'hf, 1);
    chk("ovf_pop_occ", a_occ, 8);
    chk("ovf_pop_flag", a_ovf, 0);
    push_a(32'hCC, 4'hf, 0);
    chk("ovf_drop_occ", a_occ, 8);
    chk("ovf_drop_flag", a_ovf, 1);
    a_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_data", a_qd, (i < 7) ? 32'hB1 + i : 32'hBB);
      chk("ovf_sticky", a_ovf, 1);
      tick();
    end
    a_rdy = 0;
    idle_a();
    chk("ovf_sticky_empty", a_ovf, 1);

    // Clear at occupancy 5 with a simultaneous push
    for (int i = 0; i < 5; i++) push_a(32'hD0 + i, 4'hf, 0);
    chk("clr_pre_occ", a_occ, 5);
    a_clear = 1;
    push_a(32'hEE, 4'hf, 0);
    a_clear = 0;
    idle_a();
    chk("clr_ovf", a_ovf, 0);

    // Data/strobe integrity; first beat after clear is first popped
    push_a(32'h12345678, 4'h5, 0);
    chk("int_valid", a_vv_o, 1);
    chk("int_data", a_qd, 32'h12345678);
    chk("int_strb", a_qs, 4'h5);
    chk("int_occ", a_occ, 1);
    a_rdy = 1;
    tick();
    a_rdy = 0;
    idle_a();

    // Non-power-of-two depth: ordered random stream
    sent = 0; recv = 0; max_occ = 0; cyc = 0; rdy_prev = 0;
    while (recv < 40 && cyc < 3000) begin
      b_pv  = (sent < 40) && rdy_prev && ($urandom_range(1) == 1);
      b_d   = sent;
      b_rdy = $urandom_range(1) == 1;
      if (b_occ > max_occ) max_occ = b_occ;
      if (b_vv_o && b_rdy) begin
        chk("wrap_data", b_qd, recv);
        recv++;
      end
      if (b_pv) sent++;
      rdy_prev = b_pr_o;
      tick();
      cyc++;
    end
    b_pv = 0; b_rdy = 0;
    chk("wrap_count", recv, 40);
    chk("wrap_maxocc", max_occ <= 6, 1);
    chk("wrap_ovf", b_ovf, 0);
    chk("wrap_empty", b_vv_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_fifo_earlystall_param.md
Name: hwpe_stream_fifo_earlystall_param

Overview:
- Parametrised early-stall stream FIFO: the next generation of the team's early-stall FIFO.
- Depth may be any value (not only a power of two).
- Stall margin is programmable.
- Beats are written only when they are actually accepted.
- Exposes occupancy and a sticky overflow flag.
- Sits between an HWPE streamer/producer with a known push-pipeline latency and a consumer. Lets the producer keep pushing up to STALL_MARGIN beats after push_ready_o drops.

Parameters:
- DATA_WIDTH, 32, data bits per beat; strobe width is DATA_WIDTH/8; must be a multiple of 8.
- FIFO_DEPTH, 8, number of entries; any value >= 2.
- STALL_MARGIN, 2, free slots reserved after ready deasserts; legal range 0..FIFO_DEPTH-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous flush, active-high.
- push_valid_i  in  1  producer beat valid.
- push_ready_o  out  1  early ready (see Behaviour).
- push_data_i  in  DATA_WIDTH  producer data.
- push_strb_i  in  DATA_WIDTH/8  producer byte strobes.
- pop_valid_o  out  1  output beat valid.
- pop_ready_i  in  1  consumer ready.
- pop_data_o  out  DATA_WIDTH  output data; 0 when pop_valid_o=0.
- pop_strb_o  out  DATA_WIDTH/8  output strobes; 0 when pop_valid_o=0.
- occupancy_o  out  $clog2(FIFO_DEPTH+1)  stored beat count.
- overflow_o  out  1  sticky: at least one beat was dropped.

Behaviour:
- State:
  - push pointer and pop pointer, each $clog2(FIFO_DEPTH) bits; if that is 0, use 1 bit.
  - count, 0..FIFO_DEPTH.
  - overflow flag.
  - storage array of FIFO_DEPTH entries of {data,strb}.
- Reset (rst_i=1, asynchronous): pointers=0, count=0, overflow=0, storage=0. Outputs during and after reset: push_ready_o=1, pop_valid_o=0, pop_data_o=0, pop_strb_o=0, occupancy_o=0, overflow_o=0.
- clear_i=1 at a clock edge: same values as reset, taking effect at that edge. Any push or pop in that cycle is ignored; no storage write is required.
- Reset and clear have priority over all other activity, including mid-burst.
- push_ready_o = (count < FIFO_DEPTH-STALL_MARGIN); purely a function of registered count.
- pop_valid_o = (count != 0). There is no fall-through: a beat pushed at edge N is visible on pop_o from cycle N+1 at the earliest.
- pop_data_o/pop_strb_o = storage[pop pointer] when pop_valid_o=1, else 0.
- pop = pop_valid_o & pop_ready_i.
- push = push_valid_i & (count < FIFO_DEPTH or pop). push_ready_o is not part of the accept condition: the early-stall contract allows in-flight beats into the margin.
- On push: storage[push pointer] <= {push_data_i, push_strb_i}. Storage is written only on push, never on bare push_valid_i.
- Pointer advance: increment by 1; value FIFO_DEPTH-1 wraps to 0. This is explicit and also covers non-power-of-two depths.
- count next value:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
- Full with simultaneous pop and push: both happen; count stays FIFO_DEPTH; no overflow.
- Empty: pop is impossible. A push makes pop_valid_o=1 in the next cycle.
- Overflow: push_valid_i=1 & count==FIFO_DEPTH & no pop means the beat is dropped, storage is unchanged, and overflow is set. overflow_o holds until rst_i or clear_i.
- STALL_MARGIN=0 behaves as a conventional FIFO: ready = not full.
- occupancy_o = count, registered, with no combinational path from inputs.
- All outputs except pop_data_o/pop_strb_o, which are a mux on registered state, are registered or derived only from registered state.

Test Plan:
- Reset, DEPTH=8, MARGIN=2: pulse rst_i asynchronously mid-cycle -> outputs immediately push_ready_o=1, pop_valid_o=0, pop_data_o=0, occupancy_o=0, overflow_o=0.
- Early stall, DEPTH=8, MARGIN=2, pop_ready_i=0: push 0xA0..0xA5 -> after 6th beat occupancy_o=6, push_ready_o=0. Push 0xA6, 0xA7 -> accepted, occupancy_o=8, overflow_o=0. Then pop_ready_i=1 -> output order 0xA0..0xA7; push_ready_o returns to 1 once occupancy_o=5.
- Overflow: at occupancy 8, push 0xBB with pop_ready_i=0 -> occupancy_o stays 8, overflow_o=1 next cycle, 0xBB never appears at pop_o. The same push with pop_ready_i=1 -> accepted, occupancy_o=8, overflow_o=0.
- Non-power-of-two wrap, DEPTH=6, MARGIN=1: stream 0..39 with random push_valid_i/pop_ready_i, pushing only while push_ready_o was high one cycle earlier -> all 40 values out in order, occupancy_o never exceeds 6, overflow_o=0.
- Strobe and data integrity: push data 0x12345678 with strb 0x5 -> popped unchanged. While pop_valid_o=0, pop_data_o=0 and pop_strb_o=0.
- clear_i at occupancy 5 with simultaneous push -> next cycle occupancy_o=0, pop_valid_o=0, overflow_o=0, push_ready_o=1. The pushed beat is discarded and the next pushed beat is the first popped.
